undo_reader: RTL and testbench

//  Read/pop side of the AXA undo stack, paired with the ALU-stage push path.
//  - Stores old destination values pushed by the ALU.
//  - Serves SRC_UNDO operands to register read as a registered peek at a depth from the top.
//  - Returns the top entry on pop, for the undo/jerr rollback path in reg write.
//  - Circular LIFO: the oldest entry is discarded when a push arrives while full.

---
 rtl/axa_undo_pkg.sv | 12 +
 rtl/undo_reader_if.sv | 31 +++
 rtl/undo_ram.sv | 29 ++
 rtl/undo_reader.sv | 94 +++++++++
 tb/tb_undo_reader.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axa_undo_pkg.sv
// Shared widths, encodings and word type for the AXA undo stack.
package axa_undo_pkg;

    localparam int unsigned WORD_W     = 16;
    localparam int unsigned UNDO_DEPTH = 16;
    localparam int unsigned UNDO_AW    = 4;

    localparam logic [1:0] SRC_UNDO = 2'b11;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/undo_reader_if.sv
// Push/pop/peek bus between the pipeline and the undo stack reader.
interface undo_reader_if;
    import axa_undo_pkg::*;

    logic                 push_valid;
    word_t                push_data;
    logic                 pop_req;
    logic                 pop_valid;
    word_t                pop_data;
    logic [UNDO_AW-1:0]   peek_idx;
    word_t                peek_data;
    logic                 peek_hit;
    logic [UNDO_AW:0]     count;
    logic                 empty;
    logic                 full;
    logic                 underflow;
    logic                 dropped;

    modport master (
        output push_valid, push_data, pop_req, peek_idx,
        input  pop_valid, pop_data, peek_data, peek_hit, count, empty, full,
               underflow, dropped
    );

    modport slave (
        input  push_valid, push_data, pop_req, peek_idx,
        output pop_valid, pop_data, peek_data, peek_hit, count, empty, full,
               underflow, dropped
    );

endinterface

// File: rtl/undo_ram.sv
// DEPTH x WIDTH register array: one synchronous write port, two combinational read ports.
module undo_ram #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately never cleared; count gates what is visible.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/undo_reader.sv
// Read/pop side of the AXA undo stack: circular LIFO with registered pop and peek ports.
module undo_reader
    import axa_undo_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    undo_reader_if.slave  bus
);

    localparam int unsigned WIDTH = WORD_W;
    localparam int unsigned DEPTH = UNDO_DEPTH;
    localparam int unsigned AW    = UNDO_AW;

    logic [AW-1:0] top_q, top_d;
    logic [AW:0]   count_q, count_d;
    logic          do_pop, do_under, do_drop, do_push;
    logic          we;
    logic [AW-1:0] waddr, peek_addr;
    logic          peek_hit_d;
    word_t         pop_rd, peek_rd;

    logic          pop_valid_q, peek_hit_q, underflow_q, dropped_q;
    word_t         pop_data_q, peek_data_q;

    undo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk     (clk),
        .we      (we),
        .waddr   (waddr),
        .wdata   (bus.push_data),
        .raddr_a (top_q),
        .rdata_a (pop_rd),
        .raddr_b (peek_addr),
        .rdata_b (peek_rd)
    );

    // Next pointer/count; a push paired with a real pop overwrites the top in place.
    always_comb begin
        do_push    = bus.push_valid;
        do_pop     = bus.pop_req && (count_q != '0);
        do_under   = bus.pop_req && (count_q == '0);
        do_drop    = do_push && !do_pop && (count_q == (AW+1)'(DEPTH));
        we         = do_push && !reset;
        waddr      = do_pop ? top_q : top_q + AW'(1);
        top_d      = top_q;
        count_d    = count_q;
        peek_addr  = top_q - bus.peek_idx;
        peek_hit_d = {1'b0, bus.peek_idx} < count_q;

        if (do_push && !do_pop) begin
            top_d = top_q + AW'(1);
            if (!do_drop) begin
                count_d = count_q + (AW+1)'(1);
            end
        end else if (do_pop && !do_push) begin
            top_d   = top_q - AW'(1);
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            top_q       <= '0;
            count_q     <= '0;
            pop_valid_q <= 1'b0;
            pop_data_q  <= '0;
            peek_data_q <= '0;
            peek_hit_q  <= 1'b0;
            underflow_q <= 1'b0;
            dropped_q   <= 1'b0;
        end else begin
            top_q       <= top_d;
            count_q     <= count_d;
            pop_valid_q <= do_pop;
            underflow_q <= do_under;
            dropped_q   <= do_drop;
            peek_hit_q  <= peek_hit_d;
            peek_data_q <= peek_hit_d ? peek_rd : '0;
            if (do_pop) begin
                pop_data_q <= pop_rd;
            end
        end
    end

    assign bus.pop_valid = pop_valid_q;
    assign bus.pop_data  = pop_data_q;
    assign bus.peek_data = peek_data_q;
    assign bus.peek_hit  = peek_hit_q;
    assign bus.count     = count_q;
    assign bus.underflow = underflow_q;
    assign bus.dropped   = dropped_q;
    assign bus.empty     = (count_q == '0);
    assign bus.full      = (count_q == (AW+1)'(DEPTH));

endmodule

// File: tb/tb_undo_reader.sv
// Self-checking bench for undo_reader: directed scenarios with a pop/peek scoreboard.
module tb_undo_reader;
    import axa_undo_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    word_t exp_pop_q[$];
    word_t exp_peek_q[$];
    logic  exp_hit_q[$];

    undo_reader_if bus ();

    undo_reader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input logic pv, input word_t pd, input logic pr,
                        input logic [UNDO_AW-1:0] pi);
        bus.push_valid = pv;
        bus.push_data  = pd;
        bus.pop_req    = pr;
        bus.peek_idx   = pi;
        @(posedge clk);
        #1;
        bus.push_valid = 1'b0;
        bus.pop_req    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(1'b0, '0, 1'b0, '0);
        step(1'b0, '0, 1'b0, '0);
        reset = 1'b0;
        n_tests++;
        if ({bus.count, bus.empty, bus.full, bus.pop_valid, bus.underflow, bus.dropped, bus.peek_hit}
            !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_flags: count=%0d empty=%b full=%b pv=%b uf=%b dr=%b hit=%b, want 0 1 0 0 0 0 0",
                     bus.count, bus.empty, bus.full, bus.pop_valid, bus.underflow, bus.dropped, bus.peek_hit);
        end
        n_tests++;
        if ({bus.pop_data, bus.peek_data} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: pop_data=%h peek_data=%h, want 0 0", bus.pop_data, bus.peek_data);
        end
    endtask

    task automatic test_push_peek();
        word_t vals[3] = '{16'h1111, 16'h2222, 16'h3333};
        logic [UNDO_AW-1:0] idx[3] = '{4'd0, 4'd2, 4'd3};
        word_t pexp[3] = '{16'h3333, 16'h1111, 16'h0000};
        logic  hexp[3] = '{1'b1, 1'b1, 1'b0};
        foreach (vals[i]) step(1'b1, vals[i], 1'b0, '0);
        n_tests++;
        if (bus.count !== 5'd3) begin
            n_fail++;
            $display("FAIL push3_count: got %0d want 3", bus.count);
        end
        for (int i = 0; i < 3; i++) begin
            exp_peek_q.push_back(pexp[i]);
            exp_hit_q.push_back(hexp[i]);
            step(1'b0, '0, 1'b0, idx[i]);
            n_tests++;
            if ({bus.peek_hit, bus.peek_data} !== {exp_hit_q.pop_front(), exp_peek_q.pop_front()}) begin
                n_fail++;
                $display("FAIL peek_idx%0d: got hit=%b data=%h want hit=%b data=%h",
                         idx[i], bus.peek_hit, bus.peek_data, hexp[i], pexp[i]);
            end
        end
    endtask

    task automatic test_pop();
        word_t vals[3] = '{16'h3333, 16'h2222, 16'h1111};
        foreach (vals[i]) begin
            exp_pop_q.push_back(vals[i]);
            step(1'b0, '0, 1'b1, '0);
            n_tests++;
            if (!bus.pop_valid || exp_pop_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop%0d_valid: pop_valid=%b want 1", i, bus.pop_valid);
            end else if (bus.pop_data !== exp_pop_q[0]) begin
                n_fail++;
                $display("FAIL pop%0d_data: got %h want %h", i, bus.pop_data, exp_pop_q.pop_front());
            end else begin
                void'(exp_pop_q.pop_front());
            end
        end
        step(1'b0, '0, 1'b0, '0);
        n_tests++;
        if ({bus.empty, bus.pop_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL pop_drained: empty=%b pop_valid=%b want 1 0", bus.empty, bus.pop_valid);
        end
        step(1'b0, '0, 1'b1, '0);
        n_tests++;
        if ({bus.underflow, bus.pop_valid, bus.count, bus.pop_data} !== {1'b1, 1'b0, 5'd0, 16'h1111}) begin
            n_fail++;
            $display("FAIL pop_underflow: uf=%b pv=%b count=%0d pop_data=%h want 1 0 0 1111",
                     bus.underflow, bus.pop_valid, bus.count, bus.pop_data);
        end
        step(1'b0, '0, 1'b0, '0);
        n_tests++;
        if (bus.underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL underflow_pulse: got %b want 0", bus.underflow);
        end
    endtask

    task automatic test_overflow();
        int bad_drop = 0;
        int bad_pop  = 0;
        for (int i = 0; i <= 16; i++) begin
            step(1'b1, word_t'(i), 1'b0, '0);
            if (bus.dropped !== (i == 16)) bad_drop++;
        end
        n_tests++;
        if (bad_drop != 0) begin
            n_fail++;
            $display("FAIL overflow_dropped: %0d cycles wrong, want pulse only on 17th push", bad_drop);
        end
        n_tests++;
        if ({bus.count, bus.full} !== {5'd16, 1'b1}) begin
            n_fail++;
            $display("FAIL overflow_count: count=%0d full=%b want 16 1", bus.count, bus.full);
        end
        step(1'b0, '0, 1'b0, 4'd15);
        n_tests++;
        if ({bus.peek_hit, bus.peek_data} !== {1'b1, 16'h0001}) begin
            n_fail++;
            $display("FAIL peek_deepest: hit=%b data=%h want 1 0001", bus.peek_hit, bus.peek_data);
        end
        for (int i = 16; i >= 1; i--) begin
            exp_pop_q.push_back(word_t'(i));
            step(1'b0, '0, 1'b1, '0);
            if (bus.pop_valid && exp_pop_q.size() != 0) begin
                if (bus.pop_data !== exp_pop_q.pop_front()) bad_pop++;
            end else begin
                bad_pop++;
            end
        end
        n_tests++;
        if (bad_pop != 0 || !bus.empty) begin
            n_fail++;
            $display("FAIL overflow_drain: %0d bad pops, empty=%b want 0 bad, empty=1", bad_pop, bus.empty);
        end
    endtask

    task automatic test_push_pop_same();
        step(1'b1, 16'h1111, 1'b0, '0);
        step(1'b1, 16'h2222, 1'b0, '0);
        exp_pop_q.push_back(16'h2222);
        step(1'b1, 16'hBEEF, 1'b1, '0);
        n_tests++;
        if ({bus.pop_valid, bus.pop_data, bus.count, bus.dropped} !== {1'b1, exp_pop_q.pop_front(), 5'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL pushpop_pop: pv=%b data=%h count=%0d dr=%b want 1 2222 2 0",
                     bus.pop_valid, bus.pop_data, bus.count, bus.dropped);
        end
        exp_peek_q.push_back(16'hBEEF);
        step(1'b0, '0, 1'b0, 4'd0);
        n_tests++;
        if ({bus.peek_hit, bus.peek_data} !== {1'b1, exp_peek_q.pop_front()}) begin
            n_fail++;
            $display("FAIL pushpop_peek0: hit=%b data=%h want 1 beef", bus.peek_hit, bus.peek_data);
        end
        exp_peek_q.push_back(16'h1111);
        step(1'b0, '0, 1'b0, 4'd1);
        n_tests++;
        if ({bus.peek_hit, bus.peek_data} !== {1'b1, exp_peek_q.pop_front()}) begin
            n_fail++;
            $display("FAIL pushpop_peek1: hit=%b data=%h want 1 1111", bus.peek_hit, bus.peek_data);
        end
        step(1'b0, '0, 1'b1, '0);
        step(1'b0, '0, 1'b1, '0);
    endtask

    task automatic test_push_pop_empty();
        n_tests++;
        if (bus.empty !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_empty: empty=%b want 1", bus.empty);
        end
        step(1'b1, 16'hA5A5, 1'b1, '0);
        n_tests++;
        if ({bus.underflow, bus.pop_valid, bus.count} !== {1'b1, 1'b0, 5'd1}) begin
            n_fail++;
            $display("FAIL pushpop_empty: uf=%b pv=%b count=%0d want 1 0 1",
                     bus.underflow, bus.pop_valid, bus.count);
        end
        exp_peek_q.push_back(16'hA5A5);
        step(1'b0, '0, 1'b0, 4'd0);
        n_tests++;
        if ({bus.peek_hit, bus.peek_data} !== {1'b1, exp_peek_q.pop_front()}) begin
            n_fail++;
            $display("FAIL pushpop_empty_peek: hit=%b data=%h want 1 a5a5", bus.peek_hit, bus.peek_data);
        end
    endtask

    task automatic test_reset_pop();
        for (int i = 0; i < 4; i++) step(1'b1, word_t'(16'h0C00 + i), 1'b0, '0);
        n_tests++;
        if (bus.count !== 5'd5) begin
            n_fail++;
            $display("FAIL pre_reset_count: got %0d want 5", bus.count);
        end
        reset = 1'b1;
        step(1'b0, '0, 1'b1, '0);
        reset = 1'b0;
        n_tests++;
        if ({bus.count, bus.empty, bus.pop_valid, bus.underflow} !== {5'd0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_pop: count=%0d empty=%b pv=%b uf=%b want 0 1 0 0",
                     bus.count, bus.empty, bus.pop_valid, bus.underflow);
        end
        step(1'b0, '0, 1'b0, 4'd0);
        n_tests++;
        if ({bus.peek_hit, bus.peek_data} !== {1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL reset_peek: hit=%b data=%h want 0 0000", bus.peek_hit, bus.peek_data);
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus.push_valid = 1'b0;
        bus.push_data  = '0;
        bus.pop_req    = 1'b0;
        bus.peek_idx   = '0;
        test_reset();
        test_push_peek();
        test_pop();
        test_overflow();
        test_push_pop_same();
        test_push_pop_empty();
        test_reset_pop();
        n_tests++;
        if (exp_pop_q.size() != 0 || exp_peek_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: pop=%0d peek=%0d want 0 0", exp_pop_q.size(), exp_peek_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
